fifo_uart_tx: RTL and testbench

Byte-serial UART transmitter that sits directly downstream of srl_fifo_reg. It drains the FIFO read port, pops one word per frame, and emits 8N1 frames on txd with a runtime-programmable bit period. It is the standard egress stage for host-to-device byte streams in the FPGA design.

---
 rtl/fifo_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter draining a first-word-fall-through FIFO, one word per frame.
// Optional parity bit (odd/even selectable per frame) when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     fifo_read_data,
    input  logic                      fifo_empty,
    output logic                      fifo_read_en,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
`ifdef FIFO_UART_TX_PARITY_EN
    input  logic                      parity_odd,
`endif
    output logic                      txd,
    output logic                      busy
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [PRESCALE_WIDTH-1:0] period_q, period_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      txd_q, txd_d;
    logic                      busy_q, busy_d;
    logic                      rd_en_q, rd_en_d;
    logic                      load;
    logic                      bit_end;
    logic [PRESCALE_WIDTH-1:0] start_period;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    assign start_period = (prescale == '0) ? ONE : prescale;
    assign bit_end      = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            rd_en_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            rd_en_q  <= rd_en_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        rd_en_d  = 1'b0;
        load     = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != IDLE && !bit_end) cnt_d = cnt_q - ONE;

        // txd is registered, so each bit boundary loads the value of the bit that follows
        case (state_q)
            IDLE: load = !fifo_empty;
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = period_q - ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = period_q - ONE;
                    if (idx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    cnt_d   = period_q - ONE;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start is shared by IDLE and the last STOP cycle so frames chain with no gap
        if (load) begin
            state_d  = START;
            shift_d  = fifo_read_data;
            period_d = start_period;
            cnt_d    = start_period - ONE;
            txd_d    = 1'b0;
            busy_d   = 1'b1;
            rd_en_d  = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_d    = (^fifo_read_data) ^ parity_odd;
`endif
        end
    end

    assign txd          = txd_q;
    assign busy         = busy_q;
    assign fifo_read_en = rd_en_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a model FWFT FIFO feeds the DUT and txd is decoded per frame.
module tb_fifo_uart_tx;
    localparam int DW = 8;
    localparam int PW = 16;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_read_data;
    logic          fifo_empty;
    logic          fifo_read_en;
    logic [PW-1:0] prescale;
    logic          txd;
    logic          busy;
`ifdef FIFO_UART_TX_PARITY_EN
    logic          parity_odd;
`endif

    fifo_uart_tx #(
        .DATA_WIDTH    (DW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_read_data(fifo_read_data),
        .fifo_empty    (fifo_empty),
        .fifo_read_en  (fifo_read_en),
        .prescale      (prescale),
`ifdef FIFO_UART_TX_PARITY_EN
        .parity_odd    (parity_odd),
`endif
        .txd           (txd),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Model FIFO: the stimulus process owns the write side, the clocked block owns the read side
    logic [DW-1:0] mem [256];
    logic [7:0]    wr_ptr = 8'd0;
    logic [7:0]    rd_ptr = 8'd0;
    assign fifo_empty     = (wr_ptr == rd_ptr);
    assign fifo_read_data = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_read_en && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 8'd1;
    end

    typedef struct {
        logic [DW-1:0] data;
        int            per;
        logic          odd;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  cur;
    int    n_checks = 0, n_pass = 0;
    int    cyc = 0, run = 0, last_run = 0, pops = 0, pop_gap = 0, last_pop = 0, frames = 0;
    int    off = 0, p0, f0, n, bad;
    bit    in_frame = 0, glitch = 0, prev_rd = 0;
    logic [15:0] fbits;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input logic [DW-1:0] d, input int per, input logic odd);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 8'd1;
        exp_q.push_back('{data: d, per: per, odd: odd});
    endtask

    task automatic finish_frame();
        logic [DW-1:0] got;
        got = '0;
        for (int i = 0; i < DW; i++) got[i] = fbits[i+1];
        check_eq("start_bit", fbits[0], 0);
        check_eq("data", got, cur.data);
`ifdef FIFO_UART_TX_PARITY_EN
        check_eq("parity", fbits[DW+1], (^cur.data) ^ cur.odd);
`endif
        check_eq("stop_bit", fbits[NB-1], 1);
        check_eq("bit_hold", glitch, 0);
        frames++;
        in_frame = 0;
    endtask

    // One cycle: sample at the falling edge, track busy runs, pops and the frame decoder
    task automatic tick();
        int b;
        @(negedge clk);
        cyc++;
        if (busy) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (fifo_read_en) begin
            check_eq("pop_nonempty", fifo_empty, 0);
            check_eq("pop_single", prev_rd, 0);
            check_eq("prev_frame_done", in_frame, 0);
            check_eq("sb_nonempty", exp_q.size() != 0, 1);
            pops++;
            pop_gap  = cyc - last_pop;
            last_pop = cyc;
            if (exp_q.size() != 0) begin
                cur      = exp_q.pop_front();
                in_frame = 1;
                off      = 0;
                glitch   = 0;
                fbits    = '0;
            end
        end
        prev_rd = fifo_read_en;
        if (in_frame) begin
            b = off / cur.per;
            if (off % cur.per == 0) fbits[b] = txd;
            else if (txd !== fbits[b]) glitch = 1;
            if (busy !== 1'b1) glitch = 1;
            off++;
            if (off == NB * cur.per) finish_frame();
        end
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while ((busy || in_frame || wr_ptr != rd_ptr) && k < 1000);
        check_eq({tag, "_busy_low"}, busy, 0);
        check_eq({tag, "_txd_idle"}, txd, 1);
    endtask

    initial begin
        rst      = 1'b1;
        prescale = 16'd4;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) tick();
        check_eq("rst_txd", txd, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd_en", fifo_read_en, 0);
        rst = 1'b0;
        tick();

        // single byte
        p0 = pops; f0 = frames;
        push(8'h55, 4, 1'b0);
        wait_done("single");
        check_eq("single_pops", pops - p0, 1);
        check_eq("single_busy_len", last_run, NB * 4);
        check_eq("single_frames", frames - f0, 1);

        // back-to-back frames
        prescale = 16'd2; tick();
        p0 = pops; f0 = frames;
        push(8'hA5, 2, 1'b0);
        push(8'h3C, 2, 1'b0);
        wait_done("b2b");
        check_eq("b2b_pops", pops - p0, 2);
        check_eq("b2b_pop_gap", pop_gap, NB * 2);
        check_eq("b2b_busy_len", last_run, 2 * NB * 2);
        check_eq("b2b_frames", frames - f0, 2);

        // prescale 0 behaves as 1
        prescale = 16'd0; tick();
        push(8'hFF, 1, 1'b0);
        wait_done("pre0");
        check_eq("pre0_busy_len", last_run, NB);

        // prescale change mid-frame only affects the next frame
        prescale = 16'd3; tick();
        p0 = pops; f0 = frames;
        push(8'h96, 3, 1'b0);
        push(8'h5A, 7, 1'b0);
        n = 0;
        while (pops == p0 && n < 100) begin tick(); n++; end
        repeat (5) tick();
        prescale = 16'd7;
        wait_done("prechg");
        check_eq("prechg_pop_gap", pop_gap, NB * 3);
        check_eq("prechg_busy_len", last_run, NB * 3 + NB * 7);
        check_eq("prechg_frames", frames - f0, 2);

        // empty FIFO stays quiet
        bad = 0;
        repeat (100) begin
            tick();
            if (fifo_read_en !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        check_eq("empty_quiet", bad, 0);

        // reset during data bit 3
        prescale = 16'd5; tick();
        push(8'h81, 5, 1'b0);
        n = 0;
        while (!(in_frame && off == 22) && n < 200) begin tick(); n++; end
        rst      = 1'b1;
        in_frame = 0;
        tick();
        check_eq("rst_mid_txd", txd, 1);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_rd_en", fifo_read_en, 0);
        push(8'h42, 5, 1'b0);
        tick();
        check_eq("rst_hold_no_pop", fifo_read_en, 0);
        rst = 1'b0;
        f0  = frames;
        wait_done("post_rst");
        check_eq("post_rst_frames", frames - f0, 1);
        check_eq("post_rst_busy_len", last_run, NB * 5);

`ifdef FIFO_UART_TX_PARITY_EN
        prescale = 16'd4; parity_odd = 1'b0; tick();
        push(8'h07, 4, 1'b0);
        wait_done("par_even");
        check_eq("par_even_len", last_run, 11 * 4);
        parity_odd = 1'b1; tick();
        push(8'h07, 4, 1'b1);
        wait_done("par_odd");
        check_eq("par_odd_len", last_run, 11 * 4);
`endif

        repeat (3) tick();
        check_eq("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
